// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU.
// Supports stall (hold, with WB refresh of captured operands) and flush (bubble).
module alu_operand_stage #(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int CTRLW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             IdValid,
    input  logic [XLEN-1:0]  IdRs1Data,
    input  logic [XLEN-1:0]  IdRs2Data,
    input  logic [XLEN-1:0]  IdImm,
    input  logic [REGW-1:0]  IdRs1,
    input  logic [REGW-1:0]  IdRs2,
    input  logic [REGW-1:0]  IdRd,
    input  logic             IdALUSrcB,
    input  logic [CTRLW-1:0] IdALUControl,
    input  logic             IdRegWrite,
    input  logic             MemRegWrite,
    input  logic [REGW-1:0]  MemRd,
    input  logic [XLEN-1:0]  MemALUResult,
    input  logic             WbRegWrite,
    input  logic [REGW-1:0]  WbRd,
    input  logic [XLEN-1:0]  WbResult,
    output logic [XLEN-1:0]  SrcA,
    output logic [XLEN-1:0]  SrcB,
    output logic [CTRLW-1:0] ALUControl,
    output logic [XLEN-1:0]  ExStoreData,
    output logic [REGW-1:0]  ExRd,
    output logic             ExRegWrite,
    output logic             ExValid,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB
);

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [REGW-1:0]  rs1;
        logic [REGW-1:0]  rs2;
        logic [REGW-1:0]  rd;
        logic             alu_src_b;
        logic [CTRLW-1:0] alu_control;
        logic             reg_write;
        logic             valid;
    } ex_state_t;

    ex_state_t ex_d, ex_q;

    always_comb begin
        ex_d = ex_q;
        if (Flush) begin
            ex_d = '0;
        end else if (Stall) begin
            // A result retiring from WB while we hold would otherwise be lost.
            if (WbRegWrite && (WbRd != '0) && (WbRd == ex_q.rs1))
                ex_d.rs1_data = WbResult;
            if (WbRegWrite && (WbRd != '0) && (WbRd == ex_q.rs2))
                ex_d.rs2_data = WbResult;
        end else begin
            ex_d.rs1_data    = IdRs1Data;
            ex_d.rs2_data    = IdRs2Data;
            ex_d.imm         = IdImm;
            ex_d.rs1         = IdRs1;
            ex_d.rs2         = IdRs2;
            ex_d.rd          = IdRd;
            ex_d.alu_src_b   = IdALUSrcB;
            ex_d.alu_control = IdALUControl;
            ex_d.reg_write   = IdRegWrite & IdValid;
            ex_d.valid       = IdValid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src);
        if (src == '0)                        return FWD_REG;
        else if (MemRegWrite && MemRd == src) return FWD_MEM;
        else if (WbRegWrite && WbRd == src)   return FWD_WB;
        else                                  return FWD_REG;
    endfunction

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    always_comb begin
        ForwardA = fwd_sel(ex_q.rs1);
        ForwardB = fwd_sel(ex_q.rs2);
        case (ForwardA)
            FWD_MEM: fwd_rs1 = MemALUResult;
            FWD_WB:  fwd_rs1 = WbResult;
            default: fwd_rs1 = ex_q.rs1_data;
        endcase
        case (ForwardB)
            FWD_MEM: fwd_rs2 = MemALUResult;
            FWD_WB:  fwd_rs2 = WbResult;
            default: fwd_rs2 = ex_q.rs2_data;
        endcase
    end

    assign SrcA        = fwd_rs1;
    assign ExStoreData = fwd_rs2;
    assign SrcB        = ex_q.alu_src_b ? ex_q.imm : fwd_rs2;
    assign ALUControl  = ex_q.alu_control;
    assign ExRd        = ex_q.rd;
    assign ExRegWrite  = ex_q.reg_write;
    assign ExValid     = ex_q.valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, load, forwarding priority,
// x0 guard, immediate select, stall with WB refresh, flush over stall.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset, Stall, Flush, IdValid, IdALUSrcB, IdRegWrite;
    logic [31:0] IdRs1Data, IdRs2Data, IdImm, MemALUResult, WbResult;
    logic [4:0]  IdRs1, IdRs2, IdRd, MemRd, WbRd;
    logic [3:0]  IdALUControl;
    logic        MemRegWrite, WbRegWrite;
    logic [31:0] SrcA, SrcB, ExStoreData;
    logic [3:0]  ALUControl;
    logic [4:0]  ExRd;
    logic        ExRegWrite, ExValid;
    logic [1:0]  ForwardA, ForwardB;

    int nchk = 0;
    int nerr = 0;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .IdValid(IdValid),
        .IdRs1Data(IdRs1Data), .IdRs2Data(IdRs2Data), .IdImm(IdImm),
        .IdRs1(IdRs1), .IdRs2(IdRs2), .IdRd(IdRd), .IdALUSrcB(IdALUSrcB),
        .IdALUControl(IdALUControl), .IdRegWrite(IdRegWrite),
        .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemALUResult(MemALUResult),
        .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbResult(WbResult),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .ExStoreData(ExStoreData),
        .ExRd(ExRd), .ExRegWrite(ExRegWrite), .ExValid(ExValid),
        .ForwardA(ForwardA), .ForwardB(ForwardB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic id_load(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic srcb, input logic [3:0] ctl,
                           input logic rw);
        IdValid = v; IdRs1Data = d1; IdRs2Data = d2; IdImm = imm; IdRs1 = r1; IdRs2 = r2;
        IdRd = rd; IdALUSrcB = srcb; IdALUControl = ctl; IdRegWrite = rw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        MemRegWrite = 1'b0; MemRd = '0; MemALUResult = '0;
        WbRegWrite = 1'b0; WbRd = '0; WbResult = '0;
        id_load(1'b1, 32'h1234, 32'h5678, 32'h9, 5'd1, 5'd2, 5'd3, 1'b0, 4'h5, 1'b1);
        tick(); tick();
        chk("rst_valid", ExValid, 0);
        chk("rst_regwr", ExRegWrite, 0);
        chk("rst_ctl", ALUControl, 0);
        chk("rst_rd", ExRd, 0);
        chk("rst_srca", SrcA, 0);
        chk("rst_srcb", SrcB, 0);
        chk("rst_store", ExStoreData, 0);
        chk("rst_fwd", {ForwardA, ForwardB}, 0);

        // plain load
        reset = 1'b0;
        id_load(1'b1, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 4'b0010, 1'b1);
        tick();
        chk("ld_srca", SrcA, 5);
        chk("ld_srcb", SrcB, 7);
        chk("ld_ctl", ALUControl, 4'b0010);
        chk("ld_fwd", {ForwardA, ForwardB}, 0);
        chk("ld_valid", ExValid, 1);
        chk("ld_regwr", ExRegWrite, 1);
        chk("ld_rd", ExRd, 3);

        // MEM beats WB, then WB alone
        id_load(1'b1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd8, 5'd4, 1'b0, 4'b0001, 1'b1);
        tick();
        MemRegWrite = 1'b1; MemRd = 5'd3; MemALUResult = 32'hAA;
        WbRegWrite = 1'b1; WbRd = 5'd3; WbResult = 32'hBB;
        #1;
        chk("pri_mem_srca", SrcA, 32'hAA);
        chk("pri_mem_fwda", ForwardA, 2'b10);
        chk("pri_mem_srcb", SrcB, 32'h22);
        MemRegWrite = 1'b0;
        #1;
        chk("pri_wb_srca", SrcA, 32'hBB);
        chk("pri_wb_fwda", ForwardA, 2'b01);
        WbRegWrite = 1'b0;

        // x0 guard; also IdRegWrite gated by IdValid=0
        id_load(1'b0, 32'h12, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2, 1'b0, 4'b0000, 1'b1);
        tick();
        MemRegWrite = 1'b1; MemRd = 5'd0; MemALUResult = 32'h55;
        #1;
        chk("x0_srca", SrcA, 32'h12);
        chk("x0_fwda", ForwardA, 2'b00);
        chk("inv_regwr", ExRegWrite, 0);
        chk("inv_valid", ExValid, 0);
        MemRegWrite = 1'b0;

        // immediate select with rs2 forwarded from MEM
        id_load(1'b1, 32'h1, 32'h20, 32'hFFFFFFFC, 5'd10, 5'd6, 5'd2, 1'b1, 4'b0000, 1'b1);
        tick();
        MemRegWrite = 1'b1; MemRd = 5'd6; MemALUResult = 32'd9;
        #1;
        chk("imm_srcb", SrcB, 32'hFFFFFFFC);
        chk("imm_store", ExStoreData, 32'd9);
        chk("imm_fwdb", ForwardB, 2'b10);
        MemRegWrite = 1'b0;

        // stall with WB refresh of rs1
        id_load(1'b1, 32'h1, 32'h30, 32'h0, 5'd4, 5'd5, 5'd7, 1'b0, 4'b0011, 1'b1);
        tick();
        Stall = 1'b1;
        id_load(1'b1, 32'h99, 32'h44, 32'h0, 5'd4, 5'd5, 5'd1, 1'b0, 4'b1000, 1'b1);
        WbRegWrite = 1'b1; WbRd = 5'd4; WbResult = 32'h77;
        #1;
        chk("stl_c1_srca", SrcA, 32'h77);
        chk("stl_c1_fwda", ForwardA, 2'b01);
        tick();
        WbRegWrite = 1'b0;
        #1;
        chk("stl_c2_srca", SrcA, 32'h77);
        chk("stl_c2_fwda", ForwardA, 2'b00);
        chk("stl_c2_ctl", ALUControl, 4'b0011);
        chk("stl_c2_rd", ExRd, 7);
        chk("stl_c2_srcb", SrcB, 32'h30);
        tick();
        chk("stl_hold_srca", SrcA, 32'h77);
        Stall = 1'b0;
        tick();
        chk("rel_srca", SrcA, 32'h99);
        chk("rel_srcb", SrcB, 32'h44);
        chk("rel_ctl", ALUControl, 4'b1000);
        chk("rel_rd", ExRd, 1);

        // flush beats stall
        id_load(1'b1, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd5, 1'b0, 4'b0000, 1'b1);
        tick();
        chk("pre_fl_regwr", ExRegWrite, 1);
        chk("pre_fl_rd", ExRd, 5);
        Stall = 1'b1; Flush = 1'b1;
        tick();
        chk("fl_valid", ExValid, 0);
        chk("fl_regwr", ExRegWrite, 0);
        chk("fl_ctl", ALUControl, 0);
        chk("fl_rd", ExRd, 0);
        chk("fl_srca", SrcA, 0);
        Stall = 1'b0; Flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU. It captures decoded operands and control from decode and resolves RAW hazards by forwarding from the MEM and WB stages. It drives the ALU's SrcA, SrcB and ALUControl inputs from registered state plus combinational forwarding muxes. It also supports stall (hold) and flush (bubble insertion).

Parameters:
XLEN, 32, datapath width
REGW, 5, register-address width
CTRLW, 4, ALUControl width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
Stall  in  1  hold EX contents this cycle
Flush  in  1  load bubble this cycle
IdValid  in  1  decode slot holds a real instruction
IdRs1Data  in  XLEN  register-file read port 1
IdRs2Data  in  XLEN  register-file read port 2
IdImm  in  XLEN  sign-extended immediate
IdRs1  in  REGW  source register 1 index
IdRs2  in  REGW  source register 2 index
IdRd  in  REGW  destination index
IdALUSrcB  in  1  1 = SrcB takes immediate
IdALUControl  in  CTRLW  ALU operation code
IdRegWrite  in  1  instruction writes Rd
MemRegWrite  in  1  MEM stage writes its Rd
MemRd  in  REGW  MEM stage destination
MemALUResult  in  XLEN  MEM stage result
WbRegWrite  in  1  WB stage writes its Rd
WbRd  in  REGW  WB stage destination
WbResult  in  XLEN  WB stage result
SrcA  out  XLEN  ALU operand A
SrcB  out  XLEN  ALU operand B
ALUControl  out  CTRLW  ALU operation code
ExStoreData  out  XLEN  forwarded rs2 value, for stores
ExRd  out  REGW  registered Rd
ExRegWrite  out  1  registered RegWrite, gated by valid
ExValid  out  1  EX slot valid
ForwardA  out  2  00 = reg, 01 = WB, 10 = MEM
ForwardB  out  2  same encoding, applies to rs2 path

Behaviour:
- Registered state: Rs1Data, Rs2Data, Imm, Rs1, Rs2, Rd, ALUSrcB, ALUControl, RegWrite, Valid.
- Reset: every register is 0.
  - Resulting outputs: ExValid=0, ExRegWrite=0, ALUControl=0000, ExRd=0, SrcA=0, SrcB=0, ExStoreData=0, ForwardA=ForwardB=00.
  - This assumes no forwarding matches; rs=0 never forwards.
- Per-edge priority: reset > Flush > Stall > load.
- Load (no Stall, no Flush): capture all Id* inputs.
  - Valid<=IdValid.
  - RegWrite<=IdRegWrite&IdValid.
- Flush: load a bubble.
  - All registers 0 (ALUControl=0000, the add code).
  - Flush overrides a simultaneous Stall.
- Stall: all registers hold, with one exception (WB refresh).
  - If WbRegWrite and WbRd!=0 and WbRd==Rs1, then Rs1Data<=WbResult.
  - Same rule for Rs2 / Rs2Data.
  - Purpose: a WB value that retires during a stall is not lost.
- Forwarding, combinational on registered state, per source operand s in {Rs1, Rs2}:
  - If s==0: select the register value, code 00.
  - Else if MemRegWrite and MemRd==s: MemALUResult, code 10. MEM has priority over WB.
  - Else if WbRegWrite and WbRd==s: WbResult, code 01.
  - Else: registered data, code 00.
- Operand outputs:
  - SrcA = forwarded rs1.
  - ExStoreData = forwarded rs2.
  - SrcB = Imm if ALUSrcB, else forwarded rs2.
  - ForwardB reports the rs2 path even when ALUSrcB=1.
- Other outputs:
  - ALUControl, ExRd, ExValid are direct register outputs.
  - ExRegWrite = RegWrite register.
- Latency: Id* to outputs is 1 cycle; forwarding adds 0 cycles.
- Forwarding is not gated by Valid. Bubbles have Rs1=Rs2=0, so they never forward.
- Load-use hazards, where MEM holds a load result not yet available, are detected upstream. This block's responsibility is only to honour Stall/Flush.
- No X propagation: all outputs are defined from the first cycle after reset.

Test Plan:
- Reset: assert reset with non-zero Id* inputs for 2 cycles -> ExValid=0, ALUControl=0000, SrcA=SrcB=0, ExRegWrite=0.
- Plain load: IdRs1Data=5, IdRs2Data=7, IdALUControl=0010, IdRs1=1, IdRs2=2, no Mem/Wb writes -> next cycle SrcA=5, SrcB=7, ALUControl=0010, ForwardA=ForwardB=00.
- Forward priority: registered Rs1=3, with MemRegWrite=1, MemRd=3, MemALUResult=0xAA and WbRegWrite=1, WbRd=3, WbResult=0xBB -> SrcA=0xAA, ForwardA=10. Then drop MemRegWrite -> SrcA=0xBB, ForwardA=01.
- x0 guard and immediate: Rs1=0 with MemRd=0, MemRegWrite=1, MemALUResult=0x55 -> SrcA equals the registered value, ForwardA=00. Separately, ALUSrcB=1, Imm=0xFFFFFFFC, Rs2 forwarded from MEM=9 -> SrcB=0xFFFFFFFC, ExStoreData=9.
- Stall with WB refresh: Rs1=4, Rs1Data=1; Stall=1 for 2 cycles; in cycle 1 WbRegWrite=1, WbRd=4, WbResult=0x77; in cycle 2 WB idle -> SrcA=0x77 in cycle 2, other fields unchanged. Then release Stall -> new Id* values load.
- Flush beats Stall: assert Stall=1 and Flush=1 together while holding a valid add with RegWrite=1 -> next cycle ExValid=0, ExRegWrite=0, ALUControl=0000, ExRd=0.
